// File: rtl/wave_pkg.sv
// Shared types and constants for the wave scheduler slice.
package wave_pkg;

  localparam int unsigned MAX_FREQ_ID = 24;
  localparam int unsigned NO_ID       = 31;
  localparam int unsigned ID_W        = 5;
  localparam int unsigned INDEX_W     = 11;
  localparam int unsigned HEIGHT_W    = 10;

  typedef logic [ID_W-1:0]     freq_id_t;
  typedef logic [INDEX_W-1:0]  wave_index_t;
  typedef logic [HEIGHT_W-1:0] wave_height_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StFill,
    StHold
  } wave_state_e;

  // Round-robin pointer: which requester wins when both are valid.
  typedef enum logic {
    RrPitch,
    RrGame
  } rr_sel_e;

endpackage

// File: rtl/wave_scheduler_if.sv
// Request, wave-engine and table-read signals of the wave scheduler.
interface wave_scheduler_if;
  import wave_pkg::*;

  logic         pitch_valid;
  freq_id_t     pitch_id;
  logic         pitch_ready;
  logic         game_valid;
  freq_id_t     game_id;
  logic         game_ready;

  freq_id_t     freq_id;
  logic         new_f;
  logic         wave_ready;
  wave_index_t  wave_index;
  wave_height_t wave_height;

  logic         disp_en;
  wave_index_t  disp_index;
  logic         phys_en;
  wave_index_t  phys_index;
  logic         disp_valid;
  logic         phys_valid;
  wave_height_t rd_data;
  logic         phys_gnt;

  logic         table_stable;
  freq_id_t     cur_id;
  logic         timeout_err;

  modport slave (
    input  pitch_valid, pitch_id, game_valid, game_id, wave_ready, wave_height,
           disp_en, disp_index, phys_en, phys_index,
    output pitch_ready, game_ready, freq_id, new_f, wave_index, disp_valid, phys_valid,
           rd_data, phys_gnt, table_stable, cur_id, timeout_err
  );

  modport master (
    output pitch_valid, pitch_id, game_valid, game_id, wave_ready, wave_height,
           disp_en, disp_index, phys_en, phys_index,
    input  pitch_ready, game_ready, freq_id, new_f, wave_index, disp_valid, phys_valid,
           rd_data, phys_gnt, table_stable, cur_id, timeout_err
  );

endinterface

// File: rtl/wave_read_arb.sv
// Two-stage table read port: display beats physics, index then data registered.
module wave_read_arb
  import wave_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         disp_en,
  input  wave_index_t  disp_index,
  input  logic         phys_en,
  input  wave_index_t  phys_index,
  input  wave_height_t wave_height,
  output logic         phys_gnt,
  output wave_index_t  wave_index,
  output logic         disp_valid,
  output logic         phys_valid,
  output wave_height_t rd_data
);

  logic disp_tag_q;
  logic phys_tag_q;

  assign phys_gnt = phys_en & ~disp_en;

  // Stage 1: latch the winning index and remember which requester it belongs to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wave_index <= '0;
      disp_tag_q <= 1'b0;
      phys_tag_q <= 1'b0;
    end else begin
      disp_tag_q <= disp_en;
      phys_tag_q <= phys_gnt;
      if (disp_en) begin
        wave_index <= disp_index;
      end else if (phys_en) begin
        wave_index <= phys_index;
      end
    end
  end

  // Stage 2: capture the engine's table value and tag it for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data    <= '0;
      disp_valid <= 1'b0;
      phys_valid <= 1'b0;
    end else begin
      disp_valid <= disp_tag_q;
      phys_valid <= phys_tag_q;
      if (disp_tag_q | phys_tag_q) begin
        rd_data <= wave_height;
      end
    end
  end

endmodule

// File: rtl/wave_scheduler.sv
// Arbitrates frequency requests, sequences wave-engine fills and owns the read port.
module wave_scheduler
  import wave_pkg::*;
#(
  parameter int unsigned MIN_HOLD = 4096,
  parameter int unsigned TIMEOUT  = 2048
) (
  input logic             clock,
  input logic             reset,
  wave_scheduler_if.slave bus
);

  localparam int unsigned HoldW = $clog2(MIN_HOLD + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MIN_HOLD - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

  wave_state_e      state_q;
  freq_id_t         freq_id_q;
  freq_id_t         cur_id_q;
  logic             new_f_q;
  logic             timeout_err_q;
  rr_sel_e          rr_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [TmoW-1:0]  tmo_cnt_q;

  logic     idle;
  logic     pick_pitch;
  logic     accept;
  logic     skip;
  freq_id_t req_id;

  assign idle       = (state_q == StIdle);
  assign pick_pitch = bus.pitch_valid & (~bus.game_valid | (rr_q == RrPitch));
  assign bus.pitch_ready = idle & pick_pitch;
  assign bus.game_ready  = idle & bus.game_valid & ~pick_pitch;
  assign accept     = bus.pitch_ready | bus.game_ready;
  assign req_id     = pick_pitch ? bus.pitch_id : bus.game_id;
  // Out-of-range ids and repeats of an already-loaded table are consumed without a fill;
  // after an abort the table contents are suspect, so a repeat is refilled.
  assign skip = (req_id > freq_id_t'(MAX_FREQ_ID)) | ((req_id == cur_id_q) & ~timeout_err_q);

  // Fill sequencer: accept, pulse new_f, wait for the engine, then enforce the hold-off.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      freq_id_q     <= '0;
      cur_id_q      <= freq_id_t'(NO_ID);
      new_f_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      rr_q          <= RrPitch;
      hold_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      new_f_q <= 1'b0;
      if (accept) begin
        rr_q <= bus.pitch_ready ? RrGame : RrPitch;
      end
      case (state_q)
        StIdle: begin
          if (accept && !skip) begin
            freq_id_q <= req_id;
            new_f_q   <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          tmo_cnt_q <= '0;
          state_q   <= StFill;
        end
        StFill: begin
          if (bus.wave_ready) begin
            cur_id_q      <= freq_id_q;
            timeout_err_q <= 1'b0;
            hold_cnt_q    <= '0;
            state_q       <= StHold;
          end else if (tmo_cnt_q >= TmoLast) begin
            timeout_err_q <= 1'b1;
            state_q       <= StIdle;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (hold_cnt_q >= HoldLast) begin
            state_q <= StIdle;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.freq_id      = freq_id_q;
  assign bus.new_f        = new_f_q;
  assign bus.cur_id       = cur_id_q;
  assign bus.timeout_err  = timeout_err_q;
  assign bus.table_stable = ~((state_q == StIssue) | (state_q == StFill));

  wave_read_arb u_read_arb (
    .clock       (clock),
    .reset       (reset),
    .disp_en     (bus.disp_en),
    .disp_index  (bus.disp_index),
    .phys_en     (bus.phys_en),
    .phys_index  (bus.phys_index),
    .wave_height (bus.wave_height),
    .phys_gnt    (bus.phys_gnt),
    .wave_index  (bus.wave_index),
    .disp_valid  (bus.disp_valid),
    .phys_valid  (bus.phys_valid),
    .rd_data     (bus.rd_data)
  );

endmodule

// File: tb/tb_wave_scheduler.sv
// Self-checking bench for wave_scheduler with fill and read scoreboards.
module tb_wave_scheduler;
  import wave_pkg::*;

  localparam int unsigned MinHold = 4096;
  localparam int unsigned Timeout = 2048;

  typedef struct packed {
    logic         disp;
    logic [9:0]   data;
    int           cyc;
  } rd_exp_t;

  logic     clock = 1'b0;
  logic     reset = 1'b1;
  int       n_vec = 0;
  int       n_err = 0;
  int       cyc   = 0;
  logic     rr_model;  // 0: pitch wins a tie next
  freq_id_t fill_q[$];
  rd_exp_t  rd_q[$];

  wave_scheduler_if bus ();

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Engine table model: a fixed scramble of the index.
  function automatic logic [9:0] tbl(input logic [10:0] idx);
    return 10'((idx * 11'd37) ^ 11'h155);
  endfunction

  assign bus.wave_height = tbl(bus.wave_index);

  wave_scheduler #(
    .MIN_HOLD (MinHold),
    .TIMEOUT  (Timeout)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [37:0] got;
    logic [37:0] exp;
    exp = {5'd0, 5'd31, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    #2 reset = 1'b0;
    tick(); tick();
    got = {bus.freq_id, bus.cur_id, bus.new_f, bus.wave_index, bus.rd_data, bus.disp_valid,
           bus.phys_valid, bus.timeout_err, bus.table_stable, bus.pitch_ready, bus.game_ready};
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_held: got %h want %h", got, exp);
    end
    reset = 1'b1;
    rr_model = 1'b0;
    tick(); tick();
    got = {bus.freq_id, bus.cur_id, bus.new_f, bus.wave_index, bus.rd_data, bus.disp_valid,
           bus.phys_valid, bus.timeout_err, bus.table_stable, bus.pitch_ready, bus.game_ready};
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL reset_released: got %h want %h", got, exp);
    end
  endtask

  task automatic test_single_fill();
    freq_id_t e;
    int cnt;
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd7; #1;
    n_vec++;
    if ({bus.pitch_ready, bus.game_ready} !== 2'b10) begin
      n_err++; $display("FAIL single_ready: got %b want 10", {bus.pitch_ready, bus.game_ready});
    end
    fill_q.push_back(5'd7); rr_model = 1'b1;
    tick(); bus.pitch_valid = 1'b0;
    e = fill_q.pop_front();
    n_vec++;
    if ({bus.new_f, bus.freq_id, bus.table_stable} !== {1'b1, e, 1'b0}) begin
      n_err++;
      $display("FAIL single_issue: new_f=%b freq_id=%0d stable=%b want 1/%0d/0",
               bus.new_f, bus.freq_id, bus.table_stable, e);
    end
    tick();
    n_vec++;
    if (bus.new_f !== 1'b0) begin
      n_err++; $display("FAIL single_pulse_len: new_f=%b want 0", bus.new_f);
    end
    repeat (1024) tick();
    bus.wave_ready = 1'b1; tick(); bus.wave_ready = 1'b0;
    n_vec++;
    if ({bus.cur_id, bus.table_stable, bus.freq_id} !== {5'd7, 1'b1, 5'd7}) begin
      n_err++;
      $display("FAIL single_done: cur_id=%0d stable=%b freq_id=%0d want 7/1/7",
               bus.cur_id, bus.table_stable, bus.freq_id);
    end
    // Repeat of cur_id: waits out HOLD, then is consumed without a fill.
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd7; #1;
    cnt = 0;
    while (bus.pitch_ready !== 1'b1 && cnt < int'(MinHold) + 10) begin
      cnt++; tick(); #1;
    end
    n_vec++;
    if (cnt != int'(MinHold)) begin
      n_err++; $display("FAIL single_hold_len: got %0d cycles want %0d", cnt, MinHold);
    end
    rr_model = 1'b1;
    tick(); bus.pitch_valid = 1'b0;
    n_vec++;
    if ({bus.new_f, bus.table_stable} !== 2'b01) begin
      n_err++; $display("FAIL same_id_consume: new_f=%b stable=%b want 0/1", bus.new_f,
                        bus.table_stable);
    end
  endtask

  task automatic test_alternate();
    freq_id_t e;
    logic exp_pitch;
    int cnt;
    reset = 1'b0; tick(); reset = 1'b1; rr_model = 1'b0; tick();
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd3;
    bus.game_valid  = 1'b1; bus.game_id  = 5'd9;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      while (!(bus.pitch_ready === 1'b1 || bus.game_ready === 1'b1) &&
             cnt < int'(MinHold) + 20) begin
        cnt++; tick(); #1;
      end
      exp_pitch = ~rr_model;
      n_vec++;
      if ({bus.pitch_ready, bus.game_ready} !== {exp_pitch, ~exp_pitch}) begin
        n_err++; $display("FAIL alt_winner[%0d]: ready=%b want %b", k,
                          {bus.pitch_ready, bus.game_ready}, {exp_pitch, ~exp_pitch});
      end
      if (k > 0) begin
        n_vec++;
        if (cnt != int'(MinHold)) begin
          n_err++; $display("FAIL alt_gap[%0d]: got %0d cycles want %0d", k, cnt, MinHold);
        end
      end
      fill_q.push_back(exp_pitch ? 5'd3 : 5'd9);
      rr_model = exp_pitch;
      tick();
      e = fill_q.pop_front();
      n_vec++;
      if ({bus.new_f, bus.freq_id} !== {1'b1, e}) begin
        n_err++; $display("FAIL alt_issue[%0d]: new_f=%b freq_id=%0d want 1/%0d", k,
                          bus.new_f, bus.freq_id, e);
      end
      repeat (5) tick();
      bus.wave_ready = 1'b1; tick(); bus.wave_ready = 1'b0;
      cnt = 0;
    end
    bus.pitch_valid = 1'b0; bus.game_valid = 1'b0;
  endtask

  task automatic test_consume();
    int cnt;
    bus.game_valid = 1'b1; bus.game_id = 5'd30; #1;
    cnt = 0;
    while (bus.game_ready !== 1'b1 && cnt < int'(MinHold) + 20) begin
      cnt++; tick(); #1;
    end
    n_vec++;
    if (bus.game_ready !== 1'b1) begin
      n_err++; $display("FAIL bad_id_ready: game_ready=%b want 1", bus.game_ready);
    end
    rr_model = 1'b0;
    tick(); bus.game_valid = 1'b0;
    n_vec++;
    if ({bus.new_f, bus.table_stable, bus.cur_id} !== {1'b0, 1'b1, 5'd3}) begin
      n_err++; $display("FAIL bad_id_consume: new_f=%b stable=%b cur_id=%0d want 0/1/3",
                        bus.new_f, bus.table_stable, bus.cur_id);
    end
    bus.game_valid = 1'b1; bus.game_id = 5'd3; #1;
    n_vec++;
    if (bus.game_ready !== 1'b1) begin
      n_err++; $display("FAIL dup_id_ready: game_ready=%b want 1", bus.game_ready);
    end
    tick(); bus.game_valid = 1'b0;
    n_vec++;
    if ({bus.new_f, bus.table_stable} !== 2'b01) begin
      n_err++; $display("FAIL dup_id_consume: new_f=%b stable=%b want 0/1", bus.new_f,
                        bus.table_stable);
    end
    bus.wave_ready = 1'b1; tick(); bus.wave_ready = 1'b0; tick();
    n_vec++;
    if ({bus.cur_id, bus.table_stable} !== {5'd3, 1'b1}) begin
      n_err++; $display("FAIL stray_wave_ready: cur_id=%0d stable=%b want 3/1", bus.cur_id,
                        bus.table_stable);
    end
  endtask

  task automatic test_timeout();
    freq_id_t e;
    int cnt;
    bus.game_valid = 1'b1; bus.game_id = 5'd5; #1;
    n_vec++;
    if (bus.game_ready !== 1'b1) begin
      n_err++; $display("FAIL tmo_accept: game_ready=%b want 1", bus.game_ready);
    end
    fill_q.push_back(5'd5); rr_model = 1'b0;
    tick(); bus.game_valid = 1'b0;
    e = fill_q.pop_front();
    n_vec++;
    if ({bus.new_f, bus.freq_id} !== {1'b1, e}) begin
      n_err++; $display("FAIL tmo_issue: new_f=%b freq_id=%0d want 1/%0d", bus.new_f,
                        bus.freq_id, e);
    end
    tick();
    cnt = 0;
    while (bus.table_stable === 1'b0 && cnt < int'(Timeout) + 20) begin
      cnt++; tick();
    end
    n_vec++;
    if (cnt != int'(Timeout)) begin
      n_err++; $display("FAIL tmo_len: got %0d cycles want %0d", cnt, Timeout);
    end
    n_vec++;
    if ({bus.timeout_err, bus.cur_id} !== {1'b1, 5'd3}) begin
      n_err++; $display("FAIL tmo_flag: err=%b cur_id=%0d want 1/3", bus.timeout_err,
                        bus.cur_id);
    end
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd5; #1;
    n_vec++;
    if (bus.pitch_ready !== 1'b1) begin
      n_err++; $display("FAIL tmo_retry_ready: pitch_ready=%b want 1", bus.pitch_ready);
    end
    fill_q.push_back(5'd5); rr_model = 1'b1;
    tick(); bus.pitch_valid = 1'b0;
    e = fill_q.pop_front();
    n_vec++;
    if ({bus.new_f, bus.freq_id} !== {1'b1, e}) begin
      n_err++; $display("FAIL tmo_retry_issue: new_f=%b freq_id=%0d want 1/%0d", bus.new_f,
                        bus.freq_id, e);
    end
    repeat (3) tick();
    bus.wave_ready = 1'b1; tick(); bus.wave_ready = 1'b0;
    n_vec++;
    if ({bus.cur_id, bus.timeout_err} !== {5'd5, 1'b0}) begin
      n_err++; $display("FAIL tmo_retry_done: cur_id=%0d err=%b want 5/0", bus.cur_id,
                        bus.timeout_err);
    end
  endtask

  task automatic test_reads();
    rd_exp_t e;
    bus.disp_en = 1'b1; bus.disp_index = 11'd10;
    bus.phys_en = 1'b1; bus.phys_index = 11'd20; #1;
    n_vec++;
    if (bus.phys_gnt !== 1'b0) begin
      n_err++; $display("FAIL rd_gnt_both: phys_gnt=%b want 0", bus.phys_gnt);
    end
    rd_q.push_back('{disp: 1'b1, data: tbl(11'd10), cyc: cyc});
    tick();
    n_vec++;
    if (bus.wave_index !== 11'd10) begin
      n_err++; $display("FAIL rd_index: wave_index=%0d want 10", bus.wave_index);
    end
    bus.disp_en = 1'b0; #1;
    n_vec++;
    if (bus.phys_gnt !== 1'b1) begin
      n_err++; $display("FAIL rd_gnt_phys: phys_gnt=%b want 1", bus.phys_gnt);
    end
    rd_q.push_back('{disp: 1'b0, data: tbl(11'd20), cyc: cyc});
    tick(); bus.phys_en = 1'b0;
    e = rd_q.pop_front();
    n_vec++;
    if ({bus.disp_valid, bus.phys_valid, bus.rd_data} !== {e.disp, ~e.disp, e.data}) begin
      n_err++; $display("FAIL rd_disp: dv/pv/data=%b/%b/%h want %b/%b/%h", bus.disp_valid,
                        bus.phys_valid, bus.rd_data, e.disp, ~e.disp, e.data);
    end
    tick();
    e = rd_q.pop_front();
    n_vec++;
    if ({bus.disp_valid, bus.phys_valid, bus.rd_data} !== {e.disp, ~e.disp, e.data}) begin
      n_err++; $display("FAIL rd_phys: dv/pv/data=%b/%b/%h want %b/%b/%h", bus.disp_valid,
                        bus.phys_valid, bus.rd_data, e.disp, ~e.disp, e.data);
    end
    tick();
    n_vec++;
    if ({bus.disp_valid, bus.phys_valid, bus.wave_index} !== {2'b00, 11'd20}) begin
      n_err++; $display("FAIL rd_idle: dv/pv=%b/%b wave_index=%0d want 0/0/20",
                        bus.disp_valid, bus.phys_valid, bus.wave_index);
    end
  endtask

  task automatic test_back_to_back();
    rd_exp_t e;
    for (int i = 0; i < 44; i++) begin
      if (bus.disp_valid === 1'b1 || bus.phys_valid === 1'b1) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: dv/pv=%b/%b with nothing expected",
                            bus.disp_valid, bus.phys_valid);
        end else begin
          e = rd_q.pop_front();
          if ({bus.disp_valid, bus.phys_valid, bus.rd_data} !== {e.disp, ~e.disp, e.data} ||
              cyc != e.cyc + 2) begin
            n_err++;
            $display("FAIL b2b_read: dv/pv/data=%b/%b/%h at %0d want %b/%b/%h at %0d",
                     bus.disp_valid, bus.phys_valid, bus.rd_data, cyc, e.disp, ~e.disp,
                     e.data, e.cyc + 2);
          end
        end
      end
      if (i < 40) begin
        bus.disp_en    = 1'($urandom_range(0, 1));
        bus.phys_en    = 1'($urandom_range(0, 1));
        bus.disp_index = 11'($urandom_range(0, 2047));
        bus.phys_index = 11'($urandom_range(0, 2047));
        if (bus.disp_en) rd_q.push_back('{disp: 1'b1, data: tbl(bus.disp_index), cyc: cyc});
        else if (bus.phys_en) rd_q.push_back('{disp: 1'b0, data: tbl(bus.phys_index), cyc: cyc});
      end else begin
        bus.disp_en = 1'b0; bus.phys_en = 1'b0;
      end
      tick();
    end
    n_vec++;
    if (rd_q.size() != 0) begin
      n_err++; $display("FAIL b2b_missing: %0d reads never returned, want 0", rd_q.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [37:0] got;
    logic [37:0] exp;
    int cnt;
    exp = {5'd0, 5'd31, 1'b0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd12; #1;
    cnt = 0;
    while (bus.pitch_ready !== 1'b1 && cnt < int'(MinHold) + 20) begin
      cnt++; tick(); #1;
    end
    tick(); bus.pitch_valid = 1'b0;
    n_vec++;
    if ({bus.new_f, bus.freq_id} !== {1'b1, 5'd12}) begin
      n_err++; $display("FAIL mid_issue: new_f=%b freq_id=%0d want 1/12", bus.new_f,
                        bus.freq_id);
    end
    repeat (10) tick();
    reset = 1'b0; #1;
    n_vec++;
    if ({bus.new_f, bus.table_stable, bus.cur_id} !== {1'b0, 1'b1, 5'd31}) begin
      n_err++; $display("FAIL mid_async: new_f=%b stable=%b cur_id=%0d want 0/1/31",
                        bus.new_f, bus.table_stable, bus.cur_id);
    end
    tick(); tick(); reset = 1'b1; rr_model = 1'b0;
    tick(); bus.wave_ready = 1'b1; tick(); bus.wave_ready = 1'b0; tick();
    got = {bus.freq_id, bus.cur_id, bus.new_f, bus.wave_index, bus.rd_data, bus.disp_valid,
           bus.phys_valid, bus.timeout_err, bus.table_stable, bus.pitch_ready, bus.game_ready};
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL mid_late_ready: got %h want %h", got, exp);
    end
    bus.pitch_valid = 1'b1; bus.pitch_id = 5'd12; #1;
    n_vec++;
    if (bus.pitch_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_no_hold: pitch_ready=%b want 1", bus.pitch_ready);
    end
    tick(); bus.pitch_valid = 1'b0;
    n_vec++;
    if ({bus.new_f, bus.freq_id} !== {1'b1, 5'd12}) begin
      n_err++; $display("FAIL mid_refill: new_f=%b freq_id=%0d want 1/12", bus.new_f,
                        bus.freq_id);
    end
  endtask

  initial begin
    bus.pitch_valid = 1'b0; bus.pitch_id   = '0;
    bus.game_valid  = 1'b0; bus.game_id    = '0;
    bus.wave_ready  = 1'b0;
    bus.disp_en     = 1'b0; bus.disp_index = '0;
    bus.phys_en     = 1'b0; bus.phys_index = '0;
    rr_model        = 1'b0;
    test_reset();
    test_single_fill();
    test_alternate();
    test_consume();
    test_timeout();
    test_reads();
    test_back_to_back();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wave_scheduler.md
WAVE_SCHEDULER -- requirements
Module: wave_scheduler

Interface
REQ-001 Parameter MIN_HOLD, default 4096: minimum cycles between completed fill and next commit.
REQ-002 Parameter TIMEOUT, default 2048: maximum cycles from new_f to wave_ready before abort.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 pitch_valid / pitch_id  in  1 / 5  audio-path frequency request, id 0..24.
REQ-006 pitch_ready  out  1  pitch request accepted this cycle when high with pitch_valid.
REQ-007 game_valid / game_id  in  1 / 5  game-logic frequency request, id 0..24.
REQ-008 game_ready  out  1  game request accepted this cycle when high with game_valid.
REQ-009 freq_id  out  5  id driven to wave engine; registered.
REQ-010 new_f  out  1  one-cycle start pulse to wave engine; registered.
REQ-011 wave_ready  in  1  one-cycle completion pulse from wave engine.
REQ-012 wave_index  out  11  read index driven to wave engine; registered.
REQ-013 wave_height  in  10  engine table value at wave_index.
REQ-014 disp_en / disp_index  in  1 / 11  display read request.
REQ-015 phys_en / phys_index  in  1 / 11  physics read request.
REQ-016 disp_valid / phys_valid / rd_data  out  1 / 1 / 10  read return, tagged by valid.
REQ-017 phys_gnt  out  1  physics request taken this cycle (combinational).
REQ-018 table_stable / cur_id / timeout_err  out  1 / 5 / 1  no fill in progress / last completed id / sticky abort flag.

Function
REQ-019 FSM states IDLE, ISSUE, FILL, HOLD; encoding from package.
REQ-020 IDLE: ready asserted only in IDLE and only toward the arbitration winner.
REQ-021 Both valid: round-robin, winner alternates per accept; pointer starts at pitch after reset.
REQ-022 Accepted id > 24: consumed, no fill, stay IDLE.
REQ-023 Accepted id == cur_id and timeout_err low: consumed, no fill, stay IDLE.
REQ-024 Otherwise accept registers freq_id, next state ISSUE.
REQ-025 ISSUE: new_f high exactly this one cycle; next state FILL; timeout counter cleared.
REQ-026 freq_id held constant from ISSUE until leaving FILL.
REQ-027 FILL: wave_ready -> cur_id<=freq_id, timeout_err<=0, hold counter cleared, next HOLD.
REQ-028 FILL: counter reaching TIMEOUT without wave_ready -> timeout_err<=1, cur_id unchanged, next IDLE.
REQ-029 wave_ready outside FILL ignored.
REQ-030 HOLD: count MIN_HOLD cycles, then IDLE; no requests accepted in HOLD.
REQ-031 table_stable low in ISSUE and FILL, high otherwise.
REQ-032 Read port: disp_en has absolute priority; phys_gnt = phys_en & ~disp_en.
REQ-033 Winner index registered to wave_index at edge N+1; rd_data registered from wave_height at edge N+2 with matching valid high one cycle.
REQ-034 No request at edge N+1: wave_index holds; both valids low at N+2.
REQ-035 Reads serviced in every state; fill in progress reported only via table_stable.
REQ-036 Counters saturate; never wrap.

Reset
REQ-037 reset low: state IDLE, freq_id 0, cur_id 5'd31 (none), new_f 0, wave_index 0, rd_data 0, valids 0, timeout_err 0, round-robin pointer pitch, counters 0.
REQ-038 reset asserted mid-FILL: immediate IDLE, new_f low; the in-flight wave_ready after release is ignored.

Structure
REQ-039 Package wave_pkg: MAX_FREQ_ID=24, NO_ID=31, FSM state typedef, index/height widths.
REQ-040 One sub-module wave_read_arb for REQ-032..034; FSM and request arbitration in the top.

Verification
REQ-041 pitch_valid id 7 from IDLE -> pitch_ready same cycle, new_f one cycle next cycle with freq_id 7; wave_ready 1026 cycles later -> cur_id 7, HOLD 4096 cycles.
REQ-042 pitch id 3 and game id 9 valid continuously -> accepts alternate 3,9,3 (pitch first), each separated by fill plus MIN_HOLD.
REQ-043 game id 30 -> consumed, no new_f; then id equal to cur_id -> consumed, no new_f.
REQ-044 Issue id 5, withhold wave_ready 2048 cycles -> timeout_err 1, IDLE, cur_id unchanged; id 5 re-request then fills.
REQ-045 disp_en and phys_en together, indices 10 and 20 -> phys_gnt 0, disp_valid with table[10] two cycles later; disp_en dropped -> phys_valid with table[20].
REQ-046 reset pulsed low mid-FILL, late wave_ready -> IDLE, cur_id 31, all outputs at reset values, no HOLD entry.
